// File: rtl/active_list_unit_pkg.sv
// Shared sizing, entry layout and commit bundle for the active list (reorder buffer).
// The commit struct is the single hand-off seen by the register file and the free list.
package active_list_unit_pkg;

    localparam int DEPTH  = 16;
    localparam int ID_W   = 4;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              uses_rw;
        logic [AREG_W-1:0] arch_reg;
        logic [PREG_W-1:0] new_preg;
        logic [PREG_W-1:0] old_preg;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mem_addr;
    } al_entry_t;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic              uses_rw;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mem_addr;
        logic [PREG_W-1:0] free_preg;
    } active_list_commit_t;

    typedef enum logic [0:0] {
        FL_IDLE = 1'b0,
        FL_WALK = 1'b1
    } flush_state_e;

endpackage

// File: rtl/active_list_unit.sv
// Active list: in-order allocation and retirement of renamed instructions, with a
// youngest-first walk-back on mispredict so the rename map can be rolled back.
module active_list_unit
    import active_list_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic              alloc_uses_rw,
    input  logic [AREG_W-1:0] alloc_arch_reg,
    input  logic [PREG_W-1:0] alloc_new_preg,
    input  logic [PREG_W-1:0] alloc_old_preg,
    output logic              alloc_ready,
    output logic [ID_W-1:0]   alloc_id,
    output logic              full,
    output logic              empty,
    input  logic              wb_valid,
    input  logic [ID_W-1:0]   wb_id,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_mem_addr,
    output logic              commit_valid,
    output logic [ID_W-1:0]   commit_id,
    output logic              commit_uses_rw,
    output logic [PREG_W-1:0] commit_preg,
    output logic [DATA_W-1:0] commit_data,
    output logic [DATA_W-1:0] commit_mem_addr,
    output logic [PREG_W-1:0] commit_free_preg,
    input  logic              flush_req,
    input  logic [ID_W-1:0]   flush_id,
    output logic              flush_in_progress,
    output logic              flush_map_valid,
    output logic [AREG_W-1:0] flush_arch_reg,
    output logic [PREG_W-1:0] flush_old_preg,
    output logic [PREG_W-1:0] flush_new_preg
);

    localparam logic [ID_W-1:0] ID_ONE  = ID_W'(1);
    localparam logic [ID_W:0]   PTR_ONE = (ID_W+1)'(1);
    localparam logic [ID_W:0]   CNT_MAX = (ID_W+1)'(DEPTH);

    // Pointers carry an extra wrap bit; the low ID_W bits index the entry array.
    logic [ID_W:0]   head_reg, head_next;
    logic [ID_W:0]   tail_reg, tail_next;
    logic [ID_W:0]   count_reg, count_next;
    logic [ID_W-1:0] flush_stop_reg, flush_stop_next;
    flush_state_e    state_reg, state_next;
    al_entry_t       entry_reg [DEPTH];

    logic [ID_W-1:0] head_idx, tail_idx, walk_idx;
    logic            alloc_fire, commit_fire, wb_hit, flush_accept, walk_step;
    active_list_commit_t commit_s;

    assign head_idx = head_reg[ID_W-1:0];
    assign tail_idx = tail_reg[ID_W-1:0];
    // Youngest live entry; also the one the walk-back removes next.
    assign walk_idx = tail_idx - ID_ONE;

    assign full              = (count_reg == CNT_MAX);
    assign empty             = (count_reg == '0);
    assign flush_in_progress = (state_reg == FL_WALK);
    assign walk_step         = flush_in_progress;

    assign alloc_ready = !full && !flush_in_progress;
    assign alloc_id    = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign commit_fire = !empty && entry_reg[head_idx].done && !flush_in_progress;
    assign wb_hit      = wb_valid && entry_reg[wb_id].valid;

    // A branch that is already the youngest entry has nothing to squash.
    assign flush_accept = flush_req && !flush_in_progress
                       && entry_reg[flush_id].valid && (walk_idx != flush_id);

    always_comb begin
        state_next      = state_reg;
        flush_stop_next = flush_stop_reg;
        case (state_reg)
            FL_IDLE: begin
                if (flush_accept) begin
                    state_next      = FL_WALK;
                    flush_stop_next = flush_id + ID_ONE;
                end
            end
            FL_WALK: begin
                if (walk_idx == flush_stop_reg) begin
                    state_next = FL_IDLE;
                end
            end
            default: state_next = FL_IDLE;
        endcase
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (commit_fire) begin
            head_next  = head_next + PTR_ONE;
            count_next = count_next - PTR_ONE;
        end
        if (alloc_fire) begin
            tail_next  = tail_next + PTR_ONE;
            count_next = count_next + PTR_ONE;
        end
        if (walk_step) begin
            tail_next  = tail_next - PTR_ONE;
            count_next = count_next - PTR_ONE;
        end
    end

    always_comb begin
        commit_s    = '0;
        commit_s.id = head_idx;
        if (commit_fire) begin
            commit_s.valid     = 1'b1;
            commit_s.uses_rw   = entry_reg[head_idx].uses_rw;
            commit_s.preg      = entry_reg[head_idx].new_preg;
            commit_s.data      = entry_reg[head_idx].data;
            commit_s.mem_addr  = entry_reg[head_idx].mem_addr;
            commit_s.free_preg = entry_reg[head_idx].old_preg;
        end
    end

    assign commit_valid     = commit_s.valid;
    assign commit_id        = commit_s.id;
    assign commit_uses_rw   = commit_s.uses_rw;
    assign commit_preg      = commit_s.preg;
    assign commit_data      = commit_s.data;
    assign commit_mem_addr  = commit_s.mem_addr;
    assign commit_free_preg = commit_s.free_preg;

    always_comb begin
        flush_map_valid = 1'b0;
        flush_arch_reg  = '0;
        flush_old_preg  = '0;
        flush_new_preg  = '0;
        if (walk_step) begin
            flush_map_valid = entry_reg[walk_idx].uses_rw;
            flush_arch_reg  = entry_reg[walk_idx].arch_reg;
            flush_old_preg  = entry_reg[walk_idx].old_preg;
            flush_new_preg  = entry_reg[walk_idx].new_preg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            flush_stop_reg <= '0;
            state_reg      <= FL_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            count_reg      <= count_next;
            flush_stop_reg <= flush_stop_next;
            state_reg      <= state_next;
            // Alloc/commit never target the same slot: that needs full, which blocks alloc.
            for (int i = 0; i < DEPTH; i++) begin
                if (walk_step && walk_idx == ID_W'(i)) begin
                    entry_reg[i].valid <= 1'b0;
                    entry_reg[i].done  <= 1'b0;
                end else if (alloc_fire && tail_idx == ID_W'(i)) begin
                    entry_reg[i].valid    <= 1'b1;
                    entry_reg[i].done     <= 1'b0;
                    entry_reg[i].uses_rw  <= alloc_uses_rw;
                    entry_reg[i].arch_reg <= alloc_arch_reg;
                    entry_reg[i].new_preg <= alloc_new_preg;
                    entry_reg[i].old_preg <= alloc_old_preg;
                    entry_reg[i].data     <= '0;
                    entry_reg[i].mem_addr <= '0;
                end else if (commit_fire && head_idx == ID_W'(i)) begin
                    entry_reg[i].valid <= 1'b0;
                    entry_reg[i].done  <= 1'b0;
                end else if (wb_hit && wb_id == ID_W'(i)) begin
                    entry_reg[i].done     <= 1'b1;
                    entry_reg[i].data     <= wb_data;
                    entry_reg[i].mem_addr <= wb_mem_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_active_list_unit.sv
// Directed bench for active_list_unit: reset, in-order commit, fill/wrap, flush walk-back,
// squashed write-back and no-op flush, each compared against hand-computed values.
module tb_active_list_unit;
    import active_list_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid, alloc_uses_rw;
    logic [AREG_W-1:0] alloc_arch_reg;
    logic [PREG_W-1:0] alloc_new_preg, alloc_old_preg;
    logic              alloc_ready;
    logic [ID_W-1:0]   alloc_id;
    logic              full, empty;
    logic              wb_valid;
    logic [ID_W-1:0]   wb_id;
    logic [DATA_W-1:0] wb_data, wb_mem_addr;
    logic              commit_valid;
    logic [ID_W-1:0]   commit_id;
    logic              commit_uses_rw;
    logic [PREG_W-1:0] commit_preg;
    logic [DATA_W-1:0] commit_data, commit_mem_addr;
    logic [PREG_W-1:0] commit_free_preg;
    logic              flush_req;
    logic [ID_W-1:0]   flush_id;
    logic              flush_in_progress, flush_map_valid;
    logic [AREG_W-1:0] flush_arch_reg;
    logic [PREG_W-1:0] flush_old_preg, flush_new_preg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    active_list_unit dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_uses_rw(alloc_uses_rw),
        .alloc_arch_reg(alloc_arch_reg), .alloc_new_preg(alloc_new_preg),
        .alloc_old_preg(alloc_old_preg), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .full(full), .empty(empty),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_mem_addr(wb_mem_addr),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_uses_rw(commit_uses_rw),
        .commit_preg(commit_preg), .commit_data(commit_data),
        .commit_mem_addr(commit_mem_addr), .commit_free_preg(commit_free_preg),
        .flush_req(flush_req), .flush_id(flush_id),
        .flush_in_progress(flush_in_progress), .flush_map_valid(flush_map_valid),
        .flush_arch_reg(flush_arch_reg), .flush_old_preg(flush_old_preg),
        .flush_new_preg(flush_new_preg)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc_one(input logic uses, input int arch, input int newp, input int oldp);
        alloc_valid    = 1'b1;
        alloc_uses_rw  = uses;
        alloc_arch_reg = AREG_W'(arch);
        alloc_new_preg = PREG_W'(newp);
        alloc_old_preg = PREG_W'(oldp);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic wb_one(input int id, input int data);
        wb_valid    = 1'b1;
        wb_id       = ID_W'(id);
        wb_data     = DATA_W'(data);
        wb_mem_addr = DATA_W'(32'h1000 + data);
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; alloc_valid = 1'b0; alloc_uses_rw = 1'b0; alloc_arch_reg = '0;
        alloc_new_preg = '0; alloc_old_preg = '0; wb_valid = 1'b0; wb_id = '0;
        wb_data = '0; wb_mem_addr = '0; flush_req = 1'b0; flush_id = '0;
        #1;

        // Reset state
        do_reset();
        check_val("rst_empty", empty, 1);
        check_val("rst_full", full, 0);
        check_val("rst_commit_valid", commit_valid, 0);
        check_val("rst_alloc_id", alloc_id, 0);
        check_val("rst_fip", flush_in_progress, 0);
        check_val("rst_alloc_ready", alloc_ready, 1);

        // In-order commit: B finishes first but A must retire first
        alloc_one(1'b1, 3, 40, 3);
        check_val("b_alloc_id", alloc_id, 1);
        alloc_one(1'b1, 4, 41, 4);
        check_val("two_empty", empty, 0);
        check_val("two_no_commit", commit_valid, 0);
        wb_one(1, 32'h22);
        check_val("b_done_a_not", commit_valid, 0);
        wb_valid = 1'b1; wb_id = 0; wb_data = 32'h11; wb_mem_addr = 32'h1011;
        check_val("wb_same_cycle", commit_valid, 0);
        tick();
        wb_valid = 1'b0;
        check_val("a_commit_valid", commit_valid, 1);
        check_val("a_commit_id", commit_id, 0);
        check_val("a_commit_preg", commit_preg, 40);
        check_val("a_commit_data", commit_data, 32'h11);
        check_val("a_commit_mem", commit_mem_addr, 32'h1011);
        check_val("a_commit_free", commit_free_preg, 3);
        check_val("a_commit_rw", commit_uses_rw, 1);
        tick();
        check_val("b_commit_valid", commit_valid, 1);
        check_val("b_commit_id", commit_id, 1);
        check_val("b_commit_preg", commit_preg, 41);
        check_val("b_commit_data", commit_data, 32'h22);
        check_val("b_commit_free", commit_free_preg, 4);
        tick();
        check_val("drained_empty", empty, 1);
        check_val("drained_commit", commit_valid, 0);

        // Fill to DEPTH, reject the 17th, then wrap after one commit
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            check_val($sformatf("fill_id%0d", i), alloc_id, i);
            alloc_one(1'b1, i, 16 + i, i);
        end
        check_val("fill_full", full, 1);
        check_val("fill_ready", alloc_ready, 0);
        alloc_one(1'b1, 31, 63, 31);
        check_val("reject_tail", alloc_id, 0);
        check_val("reject_full", full, 1);
        wb_one(0, 32'h55);
        alloc_valid = 1'b1;
        check_val("full_commit_valid", commit_valid, 1);
        check_val("full_alloc_blocked", alloc_ready, 0);
        tick();
        alloc_valid = 1'b0;
        check_val("after_commit_full", full, 0);
        check_val("after_commit_ready", alloc_ready, 1);
        check_val("wrap_alloc_id", alloc_id, 0);
        alloc_one(1'b1, 7, 50, 7);
        check_val("refill_full", full, 1);
        check_val("refill_alloc_id", alloc_id, 1);

        // Flush: IDs 0..4, branch at ID 2 does not write a register
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc_one(i != 2, 10 + i, 20 + i, 30 + i);
        end
        wb_valid = 1'b1; wb_id = 0; wb_data = 32'h77; wb_mem_addr = 32'h1077;
        flush_req = 1'b1; flush_id = 2;
        check_val("flush_req_fip", flush_in_progress, 0);
        tick();
        wb_valid = 1'b0; flush_req = 1'b0;
        check_val("walk1_fip", flush_in_progress, 1);
        check_val("walk1_map_valid", flush_map_valid, 1);
        check_val("walk1_arch", flush_arch_reg, 14);
        check_val("walk1_old", flush_old_preg, 34);
        check_val("walk1_new", flush_new_preg, 24);
        check_val("walk1_alloc_ready", alloc_ready, 0);
        check_val("walk1_commit_blocked", commit_valid, 0);
        tick();
        check_val("walk2_fip", flush_in_progress, 1);
        check_val("walk2_arch", flush_arch_reg, 13);
        check_val("walk2_old", flush_old_preg, 33);
        check_val("walk2_new", flush_new_preg, 23);
        tick();
        check_val("post_flush_fip", flush_in_progress, 0);
        check_val("post_flush_alloc_id", alloc_id, 3);
        check_val("post_flush_ready", alloc_ready, 1);
        check_val("post_flush_commit", commit_valid, 1);
        check_val("post_flush_commit_id", commit_id, 0);
        check_val("post_flush_commit_data", commit_data, 32'h77);
        tick();
        check_val("head1_not_done", commit_valid, 0);

        // Write-back to a squashed entry must be dropped
        wb_one(4, 32'h44);
        check_val("squashed_wb_no_commit", commit_valid, 0);
        wb_one(1, 32'h31);
        check_val("surv1_commit", commit_valid, 1);
        check_val("surv1_id", commit_id, 1);
        tick();
        wb_one(2, 32'h32);
        check_val("branch_commit", commit_valid, 1);
        check_val("branch_id", commit_id, 2);
        check_val("branch_rw", commit_uses_rw, 0);
        tick();
        check_val("after_flush_empty", empty, 1);
        check_val("id4_never_commits", commit_valid, 0);

        // Invalid flush_id is ignored
        flush_req = 1'b1; flush_id = 9;
        tick();
        flush_req = 1'b0;
        check_val("bad_flush_fip", flush_in_progress, 0);

        // No-op flush on the youngest entry
        alloc_one(1'b1, 5, 45, 5);
        flush_req = 1'b1; flush_id = 3;
        tick();
        flush_req = 1'b0;
        check_val("noop_fip", flush_in_progress, 0);
        check_val("noop_ready", alloc_ready, 1);
        check_val("noop_alloc_id", alloc_id, 4);
        alloc_one(1'b1, 6, 46, 6);
        check_val("noop_next_alloc", alloc_id, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/active_list_unit.md
Name: active_list_unit

Overview:
- Reorder buffer (active list) for the out-of-order MIPS core; sits between rename/issue and the register file.
- Allocates one entry per dispatched instruction in program order and records write-back completion and result.
- Retires entries in order, driving the register-file write and freeing the superseded physical register.
- On a branch-mispredict flush, walks back squashed entries youngest-first so the map table can be restored.

Parameters:
- DEPTH, 16: number of entries; power of two.
- ID_W, 4: instruction ID width, equal to log2(DEPTH).
- PREG_W, 6: physical register index width (64 physical registers).
- AREG_W, 5: architectural register index width.
- DATA_W, 32: result and memory-address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  dispatch request
- alloc_uses_rw  in  1  instruction writes a register
- alloc_arch_reg  in  AREG_W  destination architectural register
- alloc_new_preg  in  PREG_W  newly mapped physical register
- alloc_old_preg  in  PREG_W  previous mapping of alloc_arch_reg
- alloc_ready  out  1  allocation accepted this cycle
- alloc_id  out  ID_W  ID given to the accepted instruction (tail index)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- wb_valid  in  1  execution result available
- wb_id  in  ID_W  ID of the completing instruction
- wb_data  in  DATA_W  result value
- wb_mem_addr  in  DATA_W  memory address of the result (loads/stores)
- commit_valid  out  1  head entry retires this cycle
- commit_id  out  ID_W  head ID
- commit_uses_rw  out  1  register-file write enable
- commit_preg  out  PREG_W  register-file write address (new_preg)
- commit_data  out  DATA_W  register-file write data
- commit_mem_addr  out  DATA_W  stored memory address
- commit_free_preg  out  PREG_W  old_preg returned to the free list (valid when commit_valid && commit_uses_rw)
- flush_req  in  1  mispredict; squash all entries younger than flush_id
- flush_id  in  ID_W  ID of the mispredicted branch (the branch itself survives)
- flush_in_progress  out  1  walk-back active
- flush_map_valid  out  1  one map pairing being undone
- flush_arch_reg  out  AREG_W  architectural register to restore
- flush_old_preg  out  PREG_W  mapping to restore
- flush_new_preg  out  PREG_W  physical register to return to the free list

Behaviour:
- Storage:
  - Circular buffer with head/tail pointers of ID_W+1 bits (extra wrap bit) plus count.
  - Per entry: valid, done, uses_rw, arch_reg, new_preg, old_preg, data, mem_addr.
- Reset (on rst at clk edge):
  - head = tail = count = 0; all entries invalid.
  - All outputs 0 except empty = 1 and alloc_ready = 1.
- Allocation:
  - alloc_ready = !full && !flush_in_progress.
  - Accept when alloc_valid && alloc_ready: write entry at tail with done = 0; tail++.
  - alloc_id is combinational and equals the tail index.
  - Full is evaluated before same-cycle commit, so an alloc is rejected when full even if the head retires that cycle.
- Write-back:
  - On wb_valid, if entry wb_id is valid: set done and store data and mem_addr.
  - If the entry is invalid (squashed or never allocated), the write-back is ignored.
  - done becomes visible the cycle after.
- Commit:
  - Combinational: commit_valid = !empty && head.done && !flush_in_progress.
  - Outputs mirror the head entry; on the clock the head entry is invalidated and head++.
  - At most 1 commit per cycle.
  - Alloc and commit in the same cycle: count is unchanged.
- Flush:
  - Accepted when flush_req && !flush_in_progress && entry flush_id is valid.
  - If tail-1 == flush_id, the flush is a no-op and flush_in_progress never rises.
  - Otherwise flush_in_progress = 1 from the next cycle. Each cycle the walk-back:
    - presents entry tail-1 on flush_* (flush_map_valid = that entry's uses_rw);
    - invalidates the entry; decrements tail and count.
  - The walk-back ends after the entry at flush_id+1 is removed; flush_in_progress drops the following cycle.
  - During a flush: alloc and commit are blocked; write-backs to surviving entries are still recorded.
  - flush_req while busy, or with an invalid flush_id, is ignored.
  - rst mid-flush aborts immediately to the reset state.
- Wrap-around: all ID/pointer arithmetic is modulo DEPTH; the wrap bit distinguishes full from empty.

Decomposition:
- Shared package: DEPTH/ID_W/PREG_W/AREG_W/DATA_W constants and an entry struct typedef.
- Group the commit outputs as an active_list_commit interface/struct for the register file and free list.
- No sub-module required; optional entry RAM submodule active_list_storage.

Test Plan:
- Reset: rst for 2 cycles -> empty = 1, full = 0, commit_valid = 0, alloc_id = 0, flush_in_progress = 0.
- In-order commit:
  - Alloc A (r3, new p40, old p3) then B (r4, p41/p4).
  - WB B (data 0x22) then WB A (data 0x11).
  - -> no commit until A done; A commits (preg 40, data 0x11, free p3) the cycle after its WB; B next cycle.
- Fill:
  - 16 allocs, no WB -> full = 1, alloc_ready = 0, 17th alloc not accepted, tail unchanged.
  - Commit one -> next alloc gets ID 0 (wrap).
- Flush:
  - Alloc IDs 0..4 (ID 2 is the branch); flush_req with flush_id = 2.
  - -> flush_in_progress for 2 cycles, presenting ID 4 then ID 3 mappings; alloc_id = 3 afterwards.
- Squashed write-back: wb_valid to ID 4 after that flush -> ignored, no commit of ID 4.
- No-op flush: flush_id = tail-1 -> flush_in_progress stays 0 and allocation continues the next cycle.
